x7seg2_rx: RTL and testbench
============================

# x7seg2_rx

Two-digit seven-segment capture block. It watches a multiplexed anode/segment bus of the kind our `x7seg2` display drivers produce and decodes the segment patterns back into hex nibbles. It reassembles the byte shown on the display and pulses `valid` with it. It sits at the far end of the display interface, in self-checking benches and board-level loopback monitors, and is the inverse of the display driver.

## Interface
- `STABLE_CYCLES`, default 16: consecutive clock edges an (an, a_to_g) pair must be held before it is accepted; legal range 2..65535.
- `clk`  in  1  sole clock; all logic on rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `an`  in  2  anode selects, active-high. `01` selects the low digit, `10` the high digit, `00`/`11` mean idle.
- `a_to_g`  in  7  segments, active-high; bit 6 = a … bit 0 = g.
- `x`  out  8  last captured byte {hi, lo}; reset 8'h00.
- `valid`  out  1  one-cycle pulse when `x` is updated; reset 0.
- `err`  out  1  one-cycle pulse on acceptance of an undecodable pattern; reset 0.

## Operation
- **Input stage:** `an` and `a_to_g` are registered once (`r_an`, `r_seg`, reset 0). All decisions use the registered values.
- **Stability counter `cnt`:** width is ceil(log2(STABLE_CYCLES)), reset 0.
  - Clears to 0 whenever the new `{an, a_to_g}` differs from `{r_an, r_seg}`, or whenever `r_an` is `00` or `11`.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- **Sample event:** fires on the edge where `cnt` goes from STABLE_CYCLES-2 to STABLE_CYCLES-1. It fires exactly once per stable window. Saturation prevents re-fire until the input changes.
- **Decode table (`r_seg` → nibble):**
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1111011, A:1110111, B:0011111, C:1001110, D:0111101, E:1001111, F:1000111
  - Any other code is invalid.
- **FSM, states S_LO and S_HI; reset enters S_LO.** Behaviour on a sample event:
  - Invalid code, any state: `err` pulses, the captured low nibble is discarded, next state is S_LO.
  - S_LO with `an=01`: `lo` ← nibble, next state S_HI.
  - S_LO with `an=10`: ignored; stays in S_LO. A byte always begins with its low digit.
  - S_HI with `an=01`: `lo` is overwritten, stays in S_HI.
  - S_HI with `an=10`: `x` ← {nibble, lo}, `valid` pulses (subject to Configuration), next state S_LO.
- **No event:** FSM, `lo` and `x` hold their values.
- **`err` and `valid`** are never high in the same cycle.

## Timing
- A pattern is first present at the pins before edge e0, is captured into `r_*` at e0 and held thereafter. The sample event fires at edge e0+STABLE_CYCLES-1.
- `valid`, `err` and `x` are registered. They change at edge e0+STABLE_CYCLES, i.e. latency is STABLE_CYCLES+1 edges from the first pin-valid edge.
- `valid` and `err` are high for exactly one cycle.
- Any pattern held for fewer than STABLE_CYCLES edges, including a switching glitch between digits, produces no event.
- **`clr` high at any edge:**
  - all registers return to their reset values and the FSM enters S_LO;
  - a partially captured byte is lost;
  - `x` reads 8'h00 until the next full capture.
- `clr` has priority over every other event in the same cycle.

## Configuration
- **Macro `X7SEG2_RX_CHANGE_ONLY_EN`.**
- **Defined:**
  - On a completed capture, `valid` pulses only if the new byte differs from the current `x`.
  - `x` is written either way.
  - The first capture after reset pulses `valid` only if it is non-zero.
- **Undefined:** every completed capture pulses `valid`, including repeats of the same byte.

## Test plan
- **Basic capture:** STABLE_CYCLES=16. Drive `an=01`/`a_to_g=1110111` for 20 cycles, then `an=10`/`a_to_g=1111001` for 20 cycles → `x=8'h3A`, single `valid` pulse 17 edges after the high digit first appears, `err`=0.
- **Glitch rejection:** a 5-cycle `an=10`/`0110000` glitch inside the low-digit window, then a stable `0110011` high digit → the glitch is ignored and `x` = {4, low digit}.
- **Invalid code:** low digit A held, then `an=10`/`a_to_g=0000001` for 20 cycles → one `err` pulse, no `valid`, FSM back in S_LO, `x` unchanged.
- **Ordering and idle:** high digit first (`an=10`), then `an=11` for 30 cycles, then `an=00` → no `valid` and no `err`. A subsequent low digit 5 then high digit C → `x=8'hC5`.
- **Repeat capture:** 0x3A captured twice in succession → two `valid` pulses with the macro undefined, one pulse with `X7SEG2_RX_CHANGE_ONLY_EN` defined.
- **Reset mid-frame:** `clr` asserted for one cycle while in S_HI after a low digit of 7 → `x=8'h00`, `valid`=0. A following high digit 2 with no new low digit yields no `valid`.

Source files
------------

// File: rtl/x7seg2_rx.sv
// x7seg2_rx: recovers bytes from a multiplexed two-digit seven-segment bus.
// Optional macro X7SEG2_RX_CHANGE_ONLY_EN: valid pulses only when the captured byte changes.
module x7seg2_rx #(
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [1:0] an,
   input  logic [6:0] a_to_g,
   output logic [7:0] x,
   output logic       valid,
   output logic       err
);

   localparam int unsigned    CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_PRE = CW'(STABLE_CYCLES - 2);

   typedef enum logic {
      S_LO = 1'b0,
      S_HI = 1'b1
   } state_t;

   // Returns {code_ok, nibble}; code_ok is 0 for any non-hex pattern.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b1111110: r = {1'b1, 4'h0};
         7'b0110000: r = {1'b1, 4'h1};
         7'b1101101: r = {1'b1, 4'h2};
         7'b1111001: r = {1'b1, 4'h3};
         7'b0110011: r = {1'b1, 4'h4};
         7'b1011011: r = {1'b1, 4'h5};
         7'b1011111: r = {1'b1, 4'h6};
         7'b1110000: r = {1'b1, 4'h7};
         7'b1111111: r = {1'b1, 4'h8};
         7'b1111011: r = {1'b1, 4'h9};
         7'b1110111: r = {1'b1, 4'hA};
         7'b0011111: r = {1'b1, 4'hB};
         7'b1001110: r = {1'b1, 4'hC};
         7'b0111101: r = {1'b1, 4'hD};
         7'b1001111: r = {1'b1, 4'hE};
         7'b1000111: r = {1'b1, 4'hF};
         default:    r = 5'b0_0000;
      endcase
      return r;
   endfunction

   logic [1:0]    r_an_q;
   logic [6:0]    r_seg_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          sample_q;
   logic          sample_d;
   state_t        state_q;
   logic [3:0]    lo_q;
   logic [7:0]    x_q;
   logic          valid_q;
   logic          err_q;
   logic [4:0]    dec_s;
   logic [7:0]    byte_s;
   logic          pulse_s;

   assign dec_s  = seg_decode(r_seg_q);
   assign byte_s = {dec_s[3:0], lo_q};

`ifdef X7SEG2_RX_CHANGE_ONLY_EN
   assign pulse_s = (byte_s != x_q);
`else
   assign pulse_s = 1'b1;
`endif

   // Stability counter: restarts on any pin change or idle anode, saturates at the top.
   always_comb begin
      cnt_d = cnt_q;
      if (({an, a_to_g} != {r_an_q, r_seg_q}) || (r_an_q == 2'b00) || (r_an_q == 2'b11)) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
      sample_d = (cnt_q == CNT_PRE) && (cnt_d == CNT_MAX);
   end

   // Input stage, sample event pipeline and digit-assembly FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_an_q   <= 2'b00;
         r_seg_q  <= 7'b000_0000;
         cnt_q    <= '0;
         sample_q <= 1'b0;
         state_q  <= S_LO;
         lo_q     <= 4'h0;
         x_q      <= 8'h00;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         r_an_q   <= an;
         r_seg_q  <= a_to_g;
         cnt_q    <= cnt_d;
         sample_q <= sample_d;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         // r_* still hold the accepted pattern here: it was stable through the event edge.
         if (sample_q) begin
            if (!dec_s[4]) begin
               err_q   <= 1'b1;
               lo_q    <= 4'h0;
               state_q <= S_LO;
            end else begin
               case (state_q)
                  S_LO: begin
                     if (r_an_q == 2'b01) begin
                        lo_q    <= dec_s[3:0];
                        state_q <= S_HI;
                     end else begin
                        state_q <= S_LO;
                     end
                  end
                  S_HI: begin
                     if (r_an_q == 2'b01) begin
                        lo_q <= dec_s[3:0];
                     end else if (r_an_q == 2'b10) begin
                        x_q     <= byte_s;
                        valid_q <= pulse_s;
                        state_q <= S_LO;
                     end else begin
                        state_q <= S_HI;
                     end
                  end
                  default: state_q <= S_LO;
               endcase
            end
         end else begin
            state_q <= state_q;
         end
      end
   end

   assign x     = x_q;
   assign valid = valid_q;
   assign err   = err_q;

endmodule

// File: tb/tb_x7seg2_rx.sv
// Directed bench for x7seg2_rx at STABLE_CYCLES=16; honours X7SEG2_RX_CHANGE_ONLY_EN.
module tb_x7seg2_rx;

   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_9 = 7'b1111011;
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_C = 7'b1001110;
   localparam logic [6:0] SEG_BAD = 7'b0000001;

   logic       clk = 1'b0;
   logic       clr;
   logic [1:0] an;
   logic [6:0] a_to_g;
   logic [7:0] x;
   logic       valid;
   logic       err;

   int edge_n      = 0;
   int vcount      = 0;
   int ecount      = 0;
   int both_count  = 0;
   int last_vedge  = 0;
   int n_checks    = 0;
   int n_pass      = 0;
   int v0;
   int e0;
   int hi_start;
   int exp_rep;

   x7seg2_rx #(.STABLE_CYCLES(16)) dut (
      .clk    (clk),
      .clr    (clr),
      .an     (an),
      .a_to_g (a_to_g),
      .x      (x),
      .valid  (valid),
      .err    (err)
   );

   always #5 clk = ~clk;

   // Edge counter and pulse monitor, sampled just after each rising edge.
   always @(posedge clk) begin
      edge_n = edge_n + 1;
      #1;
      if (valid) begin
         vcount     = vcount + 1;
         last_vedge = edge_n;
      end
      if (err) ecount = ecount + 1;
      if (valid && err) both_count = both_count + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; holds the pattern for n rising edges.
   task automatic hold(input logic [1:0] a, input logic [6:0] s, input int n);
      an     = a;
      a_to_g = s;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      clr    = 1'b1;
      an     = 2'b00;
      a_to_g = 7'b000_0000;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_x", {24'd0, x}, 32'h00);
      check_eq("rst_valid", {31'd0, valid}, 32'd0);
      check_eq("rst_err", {31'd0, err}, 32'd0);
      clr = 1'b0;
      hold(2'b00, 7'b000_0000, 3);

      // Basic capture 0x3A with latency measurement
      v0 = vcount; e0 = ecount;
      hold(2'b01, SEG_A, 20);
      hi_start = edge_n + 1;
      hold(2'b10, SEG_3, 20);
      check_eq("basic_x", {24'd0, x}, 32'h3A);
      check_eq("basic_vcnt", vcount - v0, 32'd1);
      check_eq("basic_latency", last_vedge - hi_start, 32'd16);
      check_eq("basic_err", ecount - e0, 32'd0);
      hold(2'b00, 7'b000_0000, 5);

      // Glitch rejection inside the low-digit window
      v0 = vcount; e0 = ecount;
      hold(2'b01, SEG_9, 18);
      hold(2'b10, SEG_1, 5);
      hold(2'b01, SEG_9, 10);
      hold(2'b10, SEG_4, 20);
      check_eq("glitch_x", {24'd0, x}, 32'h49);
      check_eq("glitch_vcnt", vcount - v0, 32'd1);
      check_eq("glitch_err", ecount - e0, 32'd0);
      hold(2'b00, 7'b000_0000, 5);

      // Invalid high code, then a lone high digit must be ignored in S_LO
      v0 = vcount; e0 = ecount;
      hold(2'b01, SEG_A, 20);
      hold(2'b10, SEG_BAD, 20);
      check_eq("inval_err", ecount - e0, 32'd1);
      check_eq("inval_vcnt", vcount - v0, 32'd0);
      check_eq("inval_x", {24'd0, x}, 32'h49);
      hold(2'b10, SEG_3, 20);
      check_eq("inval_slo", vcount - v0, 32'd0);
      hold(2'b00, 7'b000_0000, 5);

      // High digit first, idle codes, then a proper 0xC5
      v0 = vcount; e0 = ecount;
      hold(2'b10, SEG_3, 20);
      hold(2'b11, SEG_3, 30);
      hold(2'b00, 7'b000_0000, 5);
      check_eq("order_vcnt", vcount - v0, 32'd0);
      check_eq("order_err", ecount - e0, 32'd0);
      hold(2'b01, SEG_5, 20);
      hold(2'b10, SEG_C, 20);
      check_eq("order_x", {24'd0, x}, 32'hC5);
      check_eq("order_vcnt2", vcount - v0, 32'd1);
      hold(2'b00, 7'b000_0000, 5);

      // Same byte captured twice
      v0 = vcount;
`ifdef X7SEG2_RX_CHANGE_ONLY_EN
      exp_rep = 1;
`else
      exp_rep = 2;
`endif
      hold(2'b01, SEG_A, 20);
      hold(2'b10, SEG_3, 20);
      hold(2'b01, SEG_A, 20);
      hold(2'b10, SEG_3, 20);
      check_eq("repeat_x", {24'd0, x}, 32'h3A);
      check_eq("repeat_vcnt", vcount - v0, exp_rep);
      hold(2'b00, 7'b000_0000, 5);

      // Reset while in S_HI loses the partial byte
      v0 = vcount;
      hold(2'b01, SEG_7, 20);
      an     = 2'b00;
      a_to_g = 7'b000_0000;
      clr    = 1'b1;
      @(negedge clk);
      clr    = 1'b0;
      check_eq("clr_x", {24'd0, x}, 32'h00);
      check_eq("clr_valid", {31'd0, valid}, 32'd0);
      hold(2'b10, SEG_2, 20);
      check_eq("clr_no_valid", vcount - v0, 32'd0);
      check_eq("clr_x_hold", {24'd0, x}, 32'h00);
      hold(2'b00, 7'b000_0000, 5);

      // 15-edge hold is too short; 16-edge hold is just enough
      v0 = vcount;
      hold(2'b01, SEG_6, 15);
      hold(2'b00, 7'b000_0000, 3);
      hold(2'b10, SEG_1, 20);
      check_eq("short_hold", vcount - v0, 32'd0);
      hold(2'b00, 7'b000_0000, 3);
      hold(2'b01, SEG_6, 16);
      hold(2'b00, 7'b000_0000, 3);
      hold(2'b10, SEG_1, 16);
      hold(2'b00, 7'b000_0000, 5);
      check_eq("exact_hold_x", {24'd0, x}, 32'h16);
      check_eq("exact_hold_vcnt", vcount - v0, 32'd1);

      check_eq("valid_err_excl", both_count, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
